// File: rtl/zap_branch_resolve.sv
// Execute-side branch resolution. Turns each issued branch into a registered
// clear (taken) or confirm (not-taken) pulse for the branch predictor, gives the
// fetch redirect target, squashes the wrong-path shadow after a taken branch and
// keeps saturating branch / mispredict statistics.
module zap_branch_resolve #(
    parameter int SHADOW_DEPTH = 2,
    parameter int CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear_from_writeback,
    input  logic             i_data_stall,
    input  logic             i_val,
    input  logic             i_is_branch,
    input  logic             i_cond_pass,
    input  logic [1:0]       i_bstate,
    input  logic [31:0]      i_pc_plus_8,
    input  logic [31:0]      i_target,
    output logic             o_clear_from_alu,
    output logic             o_confirm_from_alu,
    output logic [31:0]      o_pc_from_alu,
    output logic [31:0]      o_target_ff,
    output logic             o_mispredict_ff,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_mispredict_cnt
);

    typedef enum logic {IDLE, SHADOW} state_t;

    localparam logic [3:0]       DEPTH   = 4'(SHADOW_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state, state_nxt;
    logic [3:0] shadow_cnt, shadow_cnt_nxt;
    logic       accept;
    logic       predicted_taken;
    logic       mispredict;

    // States 2 and 3 (WT, ST) predict taken.
    assign predicted_taken = (i_bstate >= 2'd2);
    assign mispredict      = predicted_taken ^ i_cond_pass;
    assign o_busy          = (state == SHADOW);

    // Next-state / acceptance: flush beats stall beats normal operation.
    always_comb begin
        state_nxt      = state;
        shadow_cnt_nxt = shadow_cnt;
        accept         = 1'b0;
        if (i_clear_from_writeback) begin
            state_nxt      = IDLE;
            shadow_cnt_nxt = 4'd0;
        end else if (!i_data_stall) begin
            case (state)
                IDLE: begin
                    if (i_val && i_is_branch) begin
                        accept = 1'b1;
                        if (i_cond_pass) begin
                            state_nxt      = SHADOW;
                            shadow_cnt_nxt = DEPTH;
                        end
                    end
                end
                SHADOW: begin
                    // Only real (valid) wrong-path slots consume the shadow.
                    if (i_val) begin
                        shadow_cnt_nxt = shadow_cnt - 4'd1;
                        if (shadow_cnt <= 4'd1) begin
                            state_nxt      = IDLE;
                            shadow_cnt_nxt = 4'd0;
                        end
                    end
                end
                default: begin
                    state_nxt      = IDLE;
                    shadow_cnt_nxt = 4'd0;
                end
            endcase
        end
    end

    // State and shadow counter register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            shadow_cnt <= 4'd0;
        end else begin
            state      <= state_nxt;
            shadow_cnt <= shadow_cnt_nxt;
        end
    end

    // Feedback pulses: one cycle wide, only for an accepted branch.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_clear_from_alu   <= 1'b0;
            o_confirm_from_alu <= 1'b0;
            o_mispredict_ff    <= 1'b0;
        end else begin
            o_clear_from_alu   <= accept &  i_cond_pass;
            o_confirm_from_alu <= accept & ~i_cond_pass;
            o_mispredict_ff    <= accept &  mispredict;
        end
    end

    // Branch PC and redirect target; held whenever nothing is accepted.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_pc_from_alu <= 32'd0;
            o_target_ff   <= 32'd0;
        end else if (accept) begin
            o_pc_from_alu <= i_pc_plus_8 - 32'd8;
            if (i_cond_pass)
                o_target_ff <= i_target;
        end
    end

    // Saturating statistics; only reset clears them.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_branch_cnt     <= '0;
            o_mispredict_cnt <= '0;
        end else if (accept) begin
            if (o_branch_cnt != CNT_MAX)
                o_branch_cnt <= o_branch_cnt + 1'b1;
            if (mispredict && (o_mispredict_cnt != CNT_MAX))
                o_mispredict_cnt <= o_mispredict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_zap_branch_resolve.sv
// Directed bench for zap_branch_resolve (SHADOW_DEPTH = 2, CNT_W = 4).
// Each table row is one cycle: inputs driven, then the registered outputs
// expected after the following edge.
module tb_zap_branch_resolve;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             cwb, stall, val, br, cond;
    logic [1:0]       bst;
    logic [31:0]      pc8, tgt;
    logic             clr, cnf, mis, busy;
    logic [31:0]      pc, tgt_ff;
    logic [CNT_W-1:0] bcnt, mcnt;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    zap_branch_resolve #(.SHADOW_DEPTH(2), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_reset(reset), .i_clear_from_writeback(cwb),
        .i_data_stall(stall), .i_val(val), .i_is_branch(br),
        .i_cond_pass(cond), .i_bstate(bst), .i_pc_plus_8(pc8),
        .i_target(tgt), .o_clear_from_alu(clr), .o_confirm_from_alu(cnf),
        .o_pc_from_alu(pc), .o_target_ff(tgt_ff), .o_mispredict_ff(mis),
        .o_busy(busy), .o_branch_cnt(bcnt), .o_mispredict_cnt(mcnt)
    );

    typedef struct {
        logic        val, br, cond;
        logic [1:0]  bst;
        logic [31:0] pc8, tgt;
        logic        stall, cwb;
        logic        e_clr, e_cnf, e_mis;
        logic [31:0] e_pc, e_tgt;
        logic        e_busy;
        int          e_bc, e_mc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic check_all(input int row, input vec_t v);
        chk("clear",    row, {31'd0, clr},  {31'd0, v.e_clr});
        chk("confirm",  row, {31'd0, cnf},  {31'd0, v.e_cnf});
        chk("mispred",  row, {31'd0, mis},  {31'd0, v.e_mis});
        chk("pc",       row, pc,            v.e_pc);
        chk("target",   row, tgt_ff,        v.e_tgt);
        chk("busy",     row, {31'd0, busy}, {31'd0, v.e_busy});
        chk("br_cnt",   row, 32'(bcnt),     32'(v.e_bc));
        chk("mis_cnt",  row, 32'(mcnt),     32'(v.e_mc));
    endtask

    task automatic drive(input vec_t v);
        val = v.val; br = v.br; cond = v.cond; bst = v.bst;
        pc8 = v.pc8; tgt = v.tgt; stall = v.stall; cwb = v.cwb;
    endtask

    // v: val br cond bst pc8 tgt stall cwb | clr cnf mis pc tgt busy bc mc
    function automatic vec_t mk(logic v, logic b, logic c, logic [1:0] s, logic [31:0] p8,
                                logic [31:0] t, logic st, logic cw, logic ec, logic ef,
                                logic em, logic [31:0] ep, logic [31:0] et, logic eb,
                                int bc, int mc);
        vec_t r;
        r.val = v; r.br = b; r.cond = c; r.bst = s; r.pc8 = p8; r.tgt = t;
        r.stall = st; r.cwb = cw; r.e_clr = ec; r.e_cnf = ef; r.e_mis = em;
        r.e_pc = ep; r.e_tgt = et; r.e_busy = eb; r.e_bc = bc; r.e_mc = mc;
        return r;
    endfunction

    initial begin
        vec_t v;
        reset = 1'b1; cwb = 0; stall = 0; val = 0; br = 0; cond = 0;
        bst = 0; pc8 = 0; tgt = 0;

        // Taken branch, predicted taken; then shadow: idle slot, non-branch, branch.
        vecs.push_back(mk(1,1,1,2,32'h108,32'h400,0,0, 1,0,0,32'h100,32'h400,1, 1,0));
        vecs.push_back(mk(0,0,0,0,32'h0,  32'h0,  0,0, 0,0,0,32'h100,32'h400,1, 1,0));
        vecs.push_back(mk(1,0,0,0,32'h0,  32'h0,  0,0, 0,0,0,32'h100,32'h400,1, 1,0));
        vecs.push_back(mk(1,1,1,2,32'h508,32'h999,0,0, 0,0,0,32'h100,32'h400,0, 1,0));
        // Not-taken branch predicted strongly taken -> mispredict.
        vecs.push_back(mk(1,1,0,3,32'h208,32'h0,  0,0, 0,1,1,32'h200,32'h400,0, 2,1));
        // Non-branch in IDLE does nothing.
        vecs.push_back(mk(1,0,1,3,32'h288,32'h77, 0,0, 0,0,0,32'h200,32'h400,0, 2,1));
        // Taken mispredicted, then three back-to-back taken branches.
        vecs.push_back(mk(1,1,1,0,32'h308,32'h600,0,0, 1,0,1,32'h300,32'h600,1, 3,2));
        vecs.push_back(mk(1,1,1,3,32'h408,32'h700,0,0, 0,0,0,32'h300,32'h600,1, 3,2));
        vecs.push_back(mk(1,1,1,3,32'h408,32'h700,0,0, 0,0,0,32'h300,32'h600,0, 3,2));
        vecs.push_back(mk(1,1,1,3,32'h408,32'h700,0,0, 1,0,0,32'h400,32'h700,1, 4,2));
        // Stall in SHADOW holds, then writeback flush drops the branch.
        vecs.push_back(mk(1,1,1,3,32'h708,32'h0,  1,0, 0,0,0,32'h400,32'h700,1, 4,2));
        vecs.push_back(mk(1,1,1,3,32'h808,32'h0,  0,1, 0,0,0,32'h400,32'h700,0, 4,2));
        vecs.push_back(mk(1,1,0,1,32'h908,32'h0,  0,0, 0,1,0,32'h900,32'h700,0, 5,2));
        vecs.push_back(mk(1,1,1,2,32'hA08,32'hAAA,0,1, 0,0,0,32'h900,32'h700,0, 5,2));
        // Branch held by a 3-cycle stall, then released.
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1,1,1,2,32'hB08,32'hC00,1,0, 0,0,0,32'h900,32'h700,0, 5,2));
        vecs.push_back(mk(1,1,1,2,32'hB08,32'hC00,0,0, 1,0,0,32'hB00,32'hC00,1, 6,2));
        vecs.push_back(mk(1,1,1,2,32'hC08,32'hD00,1,0, 0,0,0,32'hB00,32'hC00,1, 6,2));
        vecs.push_back(mk(0,0,0,0,32'h0,  32'h0,  0,0, 0,0,0,32'hB00,32'hC00,1, 6,2));
        vecs.push_back(mk(0,0,0,0,32'h0,  32'h0,  0,1, 0,0,0,32'hB00,32'hC00,0, 6,2));
        // PC wrap.
        vecs.push_back(mk(1,1,0,0,32'h4,  32'h0,  0,0, 0,1,0,32'hFFFFFFFC,32'hC00,0, 7,2));
        // Not-taken mispredicts until both counters saturate at 15.
        for (int k = 0; k < 14; k++) begin
            logic [31:0] p;
            p = 32'h1008 + 32'(k * 16);
            vecs.push_back(mk(1,1,0,2,p,32'h0,0,0, 0,1,1,p - 32'd8,32'hC00,0,
                              (8 + k > 15) ? 15 : 8 + k, (3 + k > 15) ? 15 : 3 + k));
        end

        // Reset state.
        @(posedge clk); @(posedge clk); #1;
        chk("rst_clear",   -1, {31'd0, clr},  32'd0);
        chk("rst_confirm", -1, {31'd0, cnf},  32'd0);
        chk("rst_mispred", -1, {31'd0, mis},  32'd0);
        chk("rst_pc",      -1, pc,            32'd0);
        chk("rst_target",  -1, tgt_ff,        32'd0);
        chk("rst_busy",    -1, {31'd0, busy}, 32'd0);
        chk("rst_br_cnt",  -1, 32'(bcnt),     32'd0);
        chk("rst_mis_cnt", -1, 32'(mcnt),     32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clk); #1;
            check_all(i, vecs[i]);
        end

        // Reset in the middle of SHADOW with a branch on the input.
        v = mk(1,1,1,2,32'h2008,32'h3000,0,0, 1,0,0,32'h2000,32'h3000,1, 15,15);
        drive(v); @(posedge clk); #1; check_all(100, v);
        reset = 1'b1;
        @(posedge clk); #1;
        check_all(101, mk(0,0,0,0,0,0,0,0, 0,0,0,32'h0,32'h0,0, 0,0));
        reset = 1'b0;
        v = mk(1,1,0,3,32'h3008,32'h0,0,0, 0,1,1,32'h3000,32'h0,0, 1,1);
        drive(v); @(posedge clk); #1; check_all(102, v);
        // Pulse lasts one cycle only.
        v = mk(0,0,0,0,0,0,0,0, 0,0,0,32'h3000,32'h0,0, 1,1);
        drive(v); @(posedge clk); #1; check_all(103, v);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/zap_branch_resolve.md
Name: zap_branch_resolve

Overview:
- Execute-side branch resolution unit; the consumer end of the branch-prediction feedback loop.
- Takes each branch instruction from issue, with its 2-bit predictor state and the evaluated condition.
- Produces the registered clear/confirm feedback and the PC that trains the branch predictor memory, plus the fetch redirect target.
- Squashes wrong-path shadow instructions after a taken branch and keeps saturating branch/mispredict statistics.

Parameters:
- SHADOW_DEPTH, 2, number of valid instructions squashed after a taken branch (1..15).
- CNT_W, 32, width of the statistics counters.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset, synchronous, active-high
- i_clear_from_writeback  in  1  global flush
- i_data_stall  in  1  memory stall; freeze
- i_val  in  1  instruction valid this cycle
- i_is_branch  in  1  instruction is a branch
- i_cond_pass  in  1  condition evaluated true (branch actually taken)
- i_bstate  in  2  predictor state carried with the instruction (0 SNT, 1 WNT, 2 WT, 3 ST)
- i_pc_plus_8  in  32  instruction PC + 8
- i_target  in  32  computed branch target
- o_clear_from_alu  out  1  taken-branch pulse (trains predictor up; flushes front end)
- o_confirm_from_alu  out  1  not-taken-branch pulse (trains predictor down)
- o_pc_from_alu  out  32  branch instruction address (i_pc_plus_8 - 8), valid with either pulse
- o_target_ff  out  32  redirect PC, valid with o_clear_from_alu
- o_mispredict_ff  out  1  pulse: prediction disagreed with outcome
- o_busy  out  1  high while in SHADOW
- o_branch_cnt  out  CNT_W  resolved branches, saturating
- o_mispredict_cnt  out  CNT_W  mispredicts, saturating

Behaviour:
- Reset values:
  - All pulses 0; o_pc_from_alu = 0; o_target_ff = 0.
  - o_busy = 0; both counters 0; state = IDLE; shadow counter = 0.
- Predicted taken = i_bstate[1]. Actual taken = i_cond_pass.
- Priority each cycle: i_reset > i_clear_from_writeback > i_data_stall > state logic.
- Accepted input: i_val & i_is_branch, in state IDLE, with no flush and no stall. Non-branch valid instructions in IDLE produce nothing.
- Latency: every output is registered and appears exactly 1 cycle after the accepted input. Each pulse is high for exactly 1 cycle.
- Taken branch:
  - o_clear_from_alu = 1; o_pc_from_alu = i_pc_plus_8 - 8 (mod 2^32); o_target_ff = i_target.
  - Next state SHADOW, shadow counter = SHADOW_DEPTH.
- Not-taken branch:
  - o_confirm_from_alu = 1; o_pc_from_alu = i_pc_plus_8 - 8.
  - State stays IDLE.
- Clear and confirm are never high together.
- o_mispredict_ff = predicted taken XOR actual taken, registered alongside the clear/confirm pulse.
- Counters:
  - o_branch_cnt increments on every accepted branch.
  - o_mispredict_cnt increments on every mispredict.
  - Both saturate at all-ones and never wrap.
  - Counters are cleared only by i_reset.
- SHADOW state:
  - o_busy = 1.
  - Each i_val cycle, branch or not, is squashed: no pulses, no counter change. The shadow counter decrements by 1.
  - On the cycle the counter reaches 0, state returns to IDLE. The following cycle accepts input normally.
  - Cycles with i_val = 0 do not decrement the counter.
- i_data_stall:
  - No acceptance and no decrement; state, counters, o_pc_from_alu and o_target_ff hold.
  - Pulses are driven 0 during the stall cycle.
  - A pulse already registered in the cycle before the stall is not repeated.
- i_clear_from_writeback:
  - Pulses are driven 0; state returns to IDLE; shadow counter returns to 0.
  - Counters and PC registers hold.
  - A simultaneous branch input is dropped.
- Reset mid-SHADOW: returns to IDLE immediately on the next edge, with all reset values.
- PC wrap: i_pc_plus_8 = 0x00000004 gives o_pc_from_alu = 0xFFFFFFFC.

Test Plan:
- Reset, then branch i_pc_plus_8 = 0x108, i_target = 0x400, i_cond_pass = 1, i_bstate = 2 -> next cycle o_clear_from_alu = 1, o_pc_from_alu = 0x100, o_target_ff = 0x400, o_mispredict_ff = 0, o_busy = 1, o_branch_cnt = 1.
- Branch i_pc_plus_8 = 0x208, i_cond_pass = 0, i_bstate = 3 -> o_confirm_from_alu = 1, o_pc_from_alu = 0x200, o_mispredict_ff = 1, o_mispredict_cnt = 1, o_busy = 0.
- After a taken branch with SHADOW_DEPTH = 2, present 3 consecutive valid taken branches -> first two squashed (no pulses, counters unchanged), third resolved, o_busy low in the cycle it is accepted.
- Branch presented with i_data_stall = 1 for 3 cycles, then released -> no pulse during the stall; exactly one clear pulse 1 cycle after release; o_branch_cnt increments once.
- In SHADOW with counter = 2, assert i_clear_from_writeback -> o_busy = 0 next cycle; an immediately following branch is accepted and resolved.
- With CNT_W = 4 and o_branch_cnt = 15, send one more branch -> o_branch_cnt stays 15. Separately, i_pc_plus_8 = 0x4 -> o_pc_from_alu = 0xFFFFFFFC.
